// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and defaults for the hex display scheduler.
// Optional feature macro used by this block: HEX_SCHED_LOCK_EN.
package hex_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_DWELL_CYCLES = 50_000_000;

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Requester/display bundle for the hex display scheduler.
// HEX_SCHED_LOCK_EN adds i_lock, letting the owner hold the display past expiry.
interface hex_display_scheduler_if
    import hex_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
`ifdef HEX_SCHED_LOCK_EN
    logic                 i_lock;
`endif
    logic [NUM_REQ-1:0]   o_grant;
    logic [IW-1:0]        o_owner;
    logic                 o_active;
    logic [3:0]           o_num1;
    logic [3:0]           o_num2;

    // Sources side: drives requests and bytes, watches the grant.
    modport master (
`ifdef HEX_SCHED_LOCK_EN
        output i_lock,
`endif
        output i_req, i_data,
        input  o_grant, o_owner, o_active, o_num1, o_num2
    );

    modport slave (
`ifdef HEX_SCHED_LOCK_EN
        input  i_lock,
`endif
        input  i_req, i_data,
        output o_grant, o_owner, o_active, o_num1, o_num2
    );

endinterface

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       vld
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0][IW-1:0] cand;
    logic [NUM_REQ-1:0]         hit;

    // cand[i] is the requester i positions after ptr, modulo NUM_REQ.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_off
        logic [IW:0] sum;
        assign sum     = {1'b0, ptr} + (IW+1)'(i);
        assign cand[i] = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ))
                                                   : sum[IW-1:0];
        assign hit[i]  = req[cand[i]];
    end

    // Scan from the far end so the nearest offset wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
                vld = 1'b1;
            end
        end
        if (vld) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Round-robin owner of the two-digit hex display with a fixed dwell time.
// HEX_SCHED_LOCK_EN: owner may hold i_lock to keep the display across expiries.
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    hex_display_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int IW    = $clog2(NUM_REQ);

    sched_state_e         state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        ptr_q,   ptr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [7:0]           byte_q,  byte_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_vld;
    logic                 owner_req;
    logic                 expired;
    logic                 lock_hold;
    logic                 take;

    // The releasing owner's bit is already low, so the full request vector
    // serves every arbitration case.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.i_req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign owner_req = bus.i_req[owner_q];
    assign expired   = (cnt_q == CNT_W'(DWELL_CYCLES-1));
`ifdef HEX_SCHED_LOCK_EN
    assign lock_hold = bus.i_lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        take    = 1'b0;

        case (state_q)
            IDLE: take = arb_vld;
            SHOW: begin
                if (!owner_req) begin
                    // Release wins over a coincident expiry.
                    take = arb_vld;
                    if (!arb_vld) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (expired) begin
                    if (lock_hold) begin
                        cnt_d  = '0;
                        byte_d = bus.i_data[{owner_q, 3'b000} +: 8];
                    end else begin
                        take = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = SHOW;
            grant_d = arb_gnt;
            owner_d = arb_idx;
            byte_d  = bus.i_data[{arb_idx, 3'b000} +: 8];
            cnt_d   = '0;
            ptr_d   = (arb_idx == IW'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    // Owner and digits keep the last latched byte while idle.
    assign bus.o_grant  = grant_q;
    assign bus.o_owner  = owner_q;
    assign bus.o_active = (state_q == SHOW);
    assign bus.o_num1   = byte_q[7:4];
    assign bus.o_num2   = byte_q[3:0];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed plus random bench for hex_display_scheduler against a behavioural model.
module tb_hex_display_scheduler;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_display_scheduler_if #(.NUM_REQ(NR)) bus();

    hex_display_scheduler #(.NUM_REQ(NR), .DWELL_CYCLES(DW)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [NR-1:0]   req  = '0;
    logic [8*NR-1:0] data = '0;
    logic            lock = 1'b0;

    assign bus.i_req  = req;
    assign bus.i_data = data;
`ifdef HEX_SCHED_LOCK_EN
    assign bus.i_lock = lock;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model: who owns the display, for how long, and what byte.
    int         m_owner, m_ptr, m_cnt;
    bit         m_active;
    logic [7:0] m_byte;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int o = 0; o < NR; o++)
            if (r[(p + o) % NR]) return (p + o) % NR;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = 0; m_ptr = 0; m_cnt = 0; m_active = 0; m_byte = 8'h00;
    endtask

    task automatic m_give(input int w);
        m_owner  = w;
        m_active = 1;
        m_cnt    = 0;
        m_ptr    = (w + 1) % NR;
        m_byte   = data[8*w +: 8];
    endtask

    task automatic m_edge();
        int w;
        if (!m_active || !req[m_owner]) begin
            w = pick(req, m_ptr);
            if (w >= 0) m_give(w);
            else m_active = 0;
        end else if (m_cnt == DW-1) begin
            if (lock) begin
                m_cnt  = 0;
                m_byte = data[8*m_owner +: 8];
            end else begin
                m_give(pick(req, m_ptr));
            end
        end else begin
            m_cnt++;
        end
    endtask

    task automatic cmp_model();
        chk("grant",  32'(bus.o_grant),  m_active ? 32'(1 << m_owner) : 32'd0);
        chk("owner",  32'(bus.o_owner),  32'(m_owner));
        chk("active", 32'(bus.o_active), 32'(m_active));
        chk("num1",   32'(bus.o_num1),   32'(m_byte[7:4]));
        chk("num2",   32'(bus.o_num2),   32'(m_byte[3:0]));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) m_reset();
        else     m_edge();
        #1;
        cmp_model();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        m_reset();
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        m_reset();

        // Reset held with no requests.
        repeat (5) step();
        chk("rst_num1", 32'(bus.o_num1), 32'h0);
        chk("rst_grant", 32'(bus.o_grant), 32'h0);
        rst = 1'b0;

        // Single requester 2 with 0xA7, data changes ignored until recapture.
        data = $urandom;
        data[23:16] = 8'hA7;
        req = 4'b0100;
        step();
        chk("single_grant", 32'(bus.o_grant), 32'h4);
        chk("single_owner", 32'(bus.o_owner), 32'd2);
        chk("single_num1",  32'(bus.o_num1),  32'hA);
        chk("single_num2",  32'(bus.o_num2),  32'h7);
        data[23:16] = 8'h3C;
        repeat (DW-1) step();
        chk("hold_num1", 32'(bus.o_num1), 32'hA);
        data[23:16] = 8'h5E;
        step();
        chk("recap_num1", 32'(bus.o_num1), 32'h5);
        chk("recap_num2", 32'(bus.o_num2), 32'hE);

        // Three contenders rotate 0,1,3,0 with DW-cycle dwell.
        sync_reset();
        req = 4'b1011;
        data = $urandom;
        step();
        chk("rot_owner0", 32'(bus.o_owner), 32'd0);
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < DW; c++) begin
                data = $urandom;
                step();
            end
            chk("rot_owner", 32'(bus.o_owner), (k == 0) ? 32'd1 : (k == 1) ? 32'd3 : 32'd0);
        end
        repeat (DW) step();
        chk("rel_pre_owner", 32'(bus.o_owner), 32'd1);

        // Owner 1 releases early; requester 3 takes over, then all drop.
        repeat (3) step();
        req = 4'b1001;
        data[31:24] = 8'hC4;
        step();
        chk("rel_grant", 32'(bus.o_grant), 32'h8);
        req = 4'b0000;
        data = $urandom;
        step();
        chk("idle_active", 32'(bus.o_active), 32'd0);
        chk("idle_num1",   32'(bus.o_num1),   32'hC);
        chk("idle_num2",   32'(bus.o_num2),   32'h4);

        // Asynchronous reset in the middle of SHOW.
        req = 4'b1111;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        chk("arst_grant",  32'(bus.o_grant),  32'h0);
        chk("arst_active", 32'(bus.o_active), 32'h0);
        chk("arst_num",    32'({bus.o_num1, bus.o_num2}), 32'h0);
        step();
        rst = 1'b0;
        req = 4'b0110;
        step();
        chk("post_rst_grant", 32'(bus.o_grant), 32'h2);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = NR'($urandom_range(0, 15));
            data = $urandom;
`ifdef HEX_SCHED_LOCK_EN
            lock = ($urandom_range(0, 3) != 0);
`endif
            step();
        end

`ifdef HEX_SCHED_LOCK_EN
        // Lock keeps owner 0 through three expiries; unlocking rotates.
        lock = 1'b0;
        sync_reset();
        req  = 4'b0011;
        lock = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            repeat (DW) step();
            chk("lock_owner", 32'(bus.o_owner), 32'd0);
        end
        lock = 1'b0;
        repeat (DW) step();
        chk("unlock_owner", 32'(bus.o_owner), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
